// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_PREFETCH_EN selects the 2-deep prefetch configuration; the default build is 1-deep.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DEPTH_PREFETCH = 2;
  localparam int DEPTH_SINGLE   = 1;

`ifdef FETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  localparam int DEPTH = PREFETCH ? DEPTH_PREFETCH : DEPTH_SINGLE;

  // Wide enough for 0..DEPTH, shared by the buffer fill and the outstanding counter.
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding {address, instruction} pairs between memory and IF/ID.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order word fetches, buffers responses and feeds the IF/ID register.
// Buffer depth and outstanding-request limit come from fetch_pkg (FETCH_PREFETCH_EN gives 2, else 1).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch,
  input  logic [31:0] branoff,
  input  logic        trap,
  input  logic [31:0] trap_addr,
  input  logic        hz,
  input  logic        dbg,
  input  logic        mem_hold,
  output logic [31:0] ins,
  output logic [31:0] IF_ID_pres_addr
);

  localparam logic [31:0] START_PC = word_align(RESET_PC);

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      resp_pc;
  logic [31:0]      target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] buf_count;
  logic             advance;
  logic             redirect;
  logic             room;
  logic             gnt_acc;
  logic             resp_acc;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             buf_full;
  logic             buf_empty;
  logic [63:0]      head;

  assign advance   = !hz && !dbg && !mem_hold;
  assign redirect  = (trap || branch) && !dbg && !mem_hold;
  assign target    = word_align(trap ? trap_addr : branoff);

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign room      = ({1'b0, buf_count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
  assign imem_req  = (state == RUN) && room;
  assign imem_addr = pc;
  assign gnt_acc   = imem_req && imem_gnt;

  // A response with nothing outstanding belongs to a request abandoned by reset.
  assign resp_acc  = imem_rvalid && (outstanding != '0);
  assign accept    = resp_acc && (state == RUN) && !redirect;
  assign bypass    = accept && advance && buf_empty;
  assign push      = accept && !bypass && !buf_full;
  assign pop       = advance && !redirect && !buf_empty;
  assign out_next  = outstanding + CNT_W'(gnt_acc) - CNT_W'(resp_acc);

  fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (64),
    .CW    (CNT_W)
  ) u_buffer (
    .clk   (clk),
    .rst_n (Rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({resp_pc, imem_rdata}),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      pc              <= START_PC;
      resp_pc         <= START_PC;
      outstanding     <= '0;
      ins             <= BUBBLE;
      IF_ID_pres_addr <= 32'h0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        // Everything still in flight is now a discard; DRAIN swallows it before refetching.
        pc      <= target;
        resp_pc <= target;
        ins     <= BUBBLE;
        state   <= (out_next != '0) ? DRAIN : RUN;
      end else begin
        if (gnt_acc) pc <= pc + 32'd4;
        if (accept)  resp_pc <= resp_pc + 32'd4;
        case (state)
          IDLE:    state <= RUN;
          DRAIN:   if (out_next == '0) state <= RUN;
          default: state <= state;
        endcase
        if (advance) begin
          if (!buf_empty) begin
            {IF_ID_pres_addr, ins} <= head;
          end else if (bypass) begin
            ins             <= imem_rdata;
            IF_ID_pres_addr <= resp_pc;
          end else begin
            ins <= BUBBLE;
          end
        end
      end
    end
  end

endmodule
